// File: rtl/data_mem.sv
// Byte-enabled word memory with a request/response handshake and WAIT_CYC wait states.
// Optional per-byte even parity is enabled by defining DATA_MEM_PARITY_EN.
module data_mem #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                par_err
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              cap_we;
  logic              cap_err;
  logic [IDX_W-1:0]  cap_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc;
  logic [ADDR_W-1:0] word;
  logic              req_err;
  logic [IDX_W-1:0]  req_idx;
  logic              sel_we;
  logic              sel_err;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data;

`ifdef DATA_MEM_PARITY_EN
  logic [NB-1:0]     par_mem [DEPTH];
  logic [NB-1:0]     cap_be;
  logic [NB-1:0]     sel_be;
  logic [NB-1:0]     rd_par;
  logic              rd_par_bad;
`endif

  always_comb begin
    acc     = req_valid && req_ready;
    word    = req_addr >> LSB;
    req_err = ((req_addr & ADDR_W'(NB - 1)) != '0) ||
              ({1'b0, word} >= (ADDR_W + 1)'(DEPTH));
    req_idx = word[IDX_W-1:0];
  end

  // RESP is entered straight from IDLE only when WAIT_CYC is 0, so the live
  // request fields feed the read path in IDLE and the captured ones otherwise.
  always_comb begin
    sel_we  = (state == IDLE) ? req_we  : cap_we;
    sel_err = (state == IDLE) ? req_err : cap_err;
    sel_idx = (state == IDLE) ? req_idx : cap_idx;
    rd_word = mem[sel_idx];
    rd_data = (sel_we || sel_err) ? '0 : rd_word;
  end

`ifdef DATA_MEM_PARITY_EN
  always_comb begin
    sel_be     = (state == IDLE) ? req_be : cap_be;
    rd_par     = par_mem[sel_idx];
    rd_par_bad = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (sel_be[i] && ((^rd_word[8*i +: 8]) != rd_par[i]))
        rd_par_bad = 1'b1;
    end
    if (sel_we || sel_err)
      rd_par_bad = 1'b0;
  end
`endif

  // The array has no reset so that committed data survives rst_n.
  always_ff @(posedge clk) begin
    if (acc && req_we && !req_err) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (req_be[i]) begin
          mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef DATA_MEM_PARITY_EN
          par_mem[req_idx][i] <= ^req_wdata[8*i +: 8];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
      cap_be    <= '0;
      par_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            cap_we    <= req_we;
            cap_err   <= req_err;
            cap_idx   <= req_idx;
            req_ready <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
            cap_be    <= req_be;
`endif
            if (WAIT_CYC > 0) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYC - 1);
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rd_data;
              rsp_err   <= req_err;
`ifdef DATA_MEM_PARITY_EN
              par_err   <= rd_par_bad;
`endif
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_data;
            rsp_err   <= cap_err;
`ifdef DATA_MEM_PARITY_EN
            par_err   <= rd_par_bad;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
            par_err   <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef DATA_MEM_PARITY_EN
  assign par_err = 1'b0;
`endif

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width.
REQ-002 Parameter DATA_W, default 32, word width; SHALL be a multiple of 8 and at least 8.
REQ-003 Parameter DEPTH, default 256, number of words; DEPTH*(DATA_W/8) SHALL NOT exceed 2**ADDR_W.
REQ-004 Parameter WAIT_CYC, default 1, extra wait states per access, range 0..15.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 req_be  in  DATA_W/8  byte enables; bit i controls byte lane i.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  consumer accepts response.
REQ-015 rsp_rdata  out  DATA_W  read data; all-zero for writes and errored accesses.
REQ-016 rsp_err  out  1  access error: misaligned or out of range.
REQ-017 par_err  out  1  parity error on read; present only under DATA_MEM_PARITY_EN, tied 0 otherwise.

Function
REQ-018 FSM states: IDLE, WAIT, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 A request is accepted on a rising edge with req_valid=1 and req_ready=1; all request fields are captured at that edge.
REQ-021 On acceptance: IDLE->WAIT if WAIT_CYC>0, else IDLE->RESP.
REQ-022 WAIT lasts exactly WAIT_CYC cycles, counted by a down-counter loaded with WAIT_CYC-1; WAIT->RESP when it reaches 0.
REQ-023 rsp_valid SHALL rise exactly 1+WAIT_CYC cycles after the acceptance edge.
REQ-024 In RESP, rsp_valid=1 and rsp_rdata/rsp_err/par_err stay stable until rsp_valid&rsp_ready is sampled; then RESP->IDLE.
REQ-025 Misaligned access: req_addr low log2(DATA_W/8) bits non-zero -> rsp_err=1, memory unchanged.
REQ-026 Out of range: word index req_addr>>log2(DATA_W/8) >= DEPTH -> rsp_err=1, memory unchanged.
REQ-027 A write commits only the enabled byte lanes, at the acceptance edge; disabled lanes keep their old value.
REQ-028 A write with req_be all zero SHALL complete normally with rsp_err=0 and leave memory unchanged.
REQ-029 Read data is sampled from the array on the edge entering RESP; a read returns the last committed write to that word.
REQ-030 req_valid while not in IDLE has no effect; the requester SHALL hold it until accepted.
REQ-031 Memory contents are undefined after power-up; a read of a never-written word returns X in simulation and is not checked.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, par_err=0.
REQ-033 Reset SHALL NOT clear the memory array; a write accepted before reset stays committed; an in-flight response is discarded.
REQ-034 The first acceptance is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-035 Macro DATA_MEM_PARITY_EN defined: each byte lane stores an even-parity bit, written with the byte; on a read, any enabled lane whose parity mismatches sets par_err=1 in RESP. rsp_rdata still returns the stored data.
REQ-036 Macro DATA_MEM_PARITY_EN undefined: no parity storage, par_err is constant 0; all other behaviour is identical.

Verification
REQ-037 Reset, then write 0xDEADBEEF to addr 0x10 with be=0xF, WAIT_CYC=1 -> rsp_valid rises 2 cycles after acceptance with rsp_err=0; a read of 0x10 returns 0xDEADBEEF.
REQ-038 Write 0x11223344 with be=0x5 over 0xDEADBEEF at 0x10, then read -> 0xDE22BE44.
REQ-039 Read from addr 0x13 -> rsp_err=1, rsp_rdata=0; read from word index DEPTH -> rsp_err=1.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0 throughout; response completes on the cycle rsp_ready=1.
REQ-041 Assert rst_n=0 mid-WAIT -> rsp_valid=0 and req_ready=1 immediately; earlier committed data is still readable after reset.
REQ-042 With DATA_MEM_PARITY_EN, force a stored parity bit flip on lane 2, then read -> par_err=1; with WAIT_CYC=0, a read responds 1 cycle after acceptance.
